// File: rtl/johnson_monitor_if.sv
// johnson_monitor_if: groups the Johnson monitor's sample inputs and its
// status outputs so that the monitor and its driver share one port bundle.
//   code_in    : Johnson code from the counter (WIDTH bits)
//   up_down    : the direction control that is also driven into the counter
//   index      : decoded position 0..2*WIDTH-1
//   valid      : tracking, and the current sample is legal
//   illegal    : the current sample is not a Johnson code
//   step_err   : one-cycle pulse on a bad step
//   fault      : monitor is in its FAULT state
//   wrap_count : signed net wrap count (two's complement, modular)
//   err_count  : saturating error count
// The master modport drives the samples; the slave modport (the monitor)
// drives the status outputs.
interface johnson_monitor_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4
);
    logic [WIDTH-1:0]  code_in;
    logic              up_down;
    logic [IDX_W-1:0]  index;
    logic              valid;
    logic              illegal;
    logic              step_err;
    logic              fault;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output code_in, up_down,
        input  index, valid, illegal, step_err, fault, wrap_count, err_count
    );

    modport slave (
        input  code_in, up_down,
        output index, valid, illegal, step_err, fault, wrap_count, err_count
    );
endinterface

// File: rtl/johnson_monitor.sv
// johnson_monitor: downstream checker for a WIDTH-bit Johnson counter.
// Every clock edge it samples the counter's code and direction, decodes the
// code to a binary index, flags codes that are not Johnson codes, checks that
// each step moves at most one position in the commanded direction, and keeps
// a signed wrap count plus a saturating error count. All outputs are
// registered, so they describe the sample taken at the preceding edge.
// Ports:
//   clock : system clock, all state updates on posedge
//   reset : asynchronous, active-high reset
//   bus   : johnson_monitor_if slave (code_in/up_down in, status out)
module johnson_monitor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    johnson_monitor_if.slave    bus
);
    typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);

    state_t             state_q, state_d;
    // The index output doubles as the previous position for step checking.
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;
    logic               step_err_q, step_err_d;
    logic               fault_q, fault_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               legal;
    logic [IDX_W-1:0]   ones;
    logic [IDX_W-1:0]   dec;
    logic [IDX_W-1:0]   next_up, next_dn;
    logic               accepted;
    logic               err_inc;

    // Decode: a legal code is a thermometer of ones (msb=0) or of zeros
    // (msb=1) filled from the LSB. A bit that differs from the bit below it
    // and also differs from the msb breaks the thermometer.
    always_comb begin
        legal = 1'b1;
        ones  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.code_in[i]) ones = ones + IDX_W'(1);
        end
        for (int unsigned i = 1; i < WIDTH; i++) begin
            if ((bus.code_in[i] != bus.code_in[i-1]) &&
                (bus.code_in[i] != bus.code_in[WIDTH-1])) legal = 1'b0;
        end
        // msb=1: WIDTH + zero count = 2*WIDTH - ones (modular in IDX_W)
        dec = bus.code_in[WIDTH-1] ? (IDX_W'(2 * WIDTH) - ones) : ones;
    end

    always_comb begin
        next_up  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        next_dn  = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        accepted = (dec == idx_q) || (dec == (dir_q ? next_up : next_dn));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_d      = bus.up_down;
        valid_d    = 1'b0;
        illegal_d  = ~legal;
        step_err_d = 1'b0;
        wrap_d     = wrap_q;
        err_inc    = 1'b0;

        case (state_q)
            ACQUIRE: begin
                if (legal) begin
                    idx_d   = dec;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!legal) begin
                    // Illegal sample wins over any step check.
                    state_d = FAULT;
                    err_inc = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    idx_d   = dec;
                    if (accepted) begin
                        if (dir_q && (idx_q == LAST_IDX) && (dec == '0))
                            wrap_d = wrap_q + WRAP_W'(1);
                        else if (!dir_q && (idx_q == '0) && (dec == LAST_IDX))
                            wrap_d = wrap_q - WRAP_W'(1);
                    end else begin
                        step_err_d = 1'b1;
                        err_inc    = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (legal) begin
                    idx_d   = dec;
                    state_d = ACQUIRE;
                end
            end
            default: state_d = ACQUIRE;
        endcase

        err_d   = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ACQUIRE;
            idx_q      <= '0;
            dir_q      <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            step_err_q <= 1'b0;
            fault_q    <= 1'b0;
            wrap_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            step_err_q <= step_err_d;
            fault_q    <= fault_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign bus.index      = idx_q;
    assign bus.valid      = valid_q;
    assign bus.illegal    = illegal_q;
    assign bus.step_err   = step_err_q;
    assign bus.fault      = fault_q;
    assign bus.wrap_count = wrap_q;
    assign bus.err_count  = err_q;
endmodule
